spm_arbiter: RTL
================

# spm_arbiter

Two-requester arbiter for the single-port scratch-pad memory (SPM). It shares the SPM between the instruction-fetch port and the MEM-stage bus interface. The SPM has a synchronous read (data valid one cycle after the address edge), so the arbiter tracks which port owns the in-flight read and returns the data to that port. It produces per-port grant signals that the pipeline control uses as stall conditions.

## Interface
- STARVE_LIMIT, 4: maximum consecutive MEM grants while IF is waiting; legal range 1–15.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_addr  in  `WORD_ADDR_BUS`  fetch word address.
- if_as_  in  1  fetch address strobe, active-low (`ENABLE_`); always a read.
- if_gnt  out  1  fetch request accepted at this edge (combinational).
- if_rvalid  out  1  spm_rd_data belongs to fetch this cycle (registered).
- mem_addr  in  `WORD_ADDR_BUS`  MEM-stage word address.
- mem_as_  in  1  MEM-stage strobe, active-low.
- mem_rw  in  1  `READ` or `WRITE`.
- mem_wr_data  in  `WORD_DATA_BUS`  MEM-stage write data.
- mem_gnt  out  1  MEM request accepted at this edge (combinational).
- mem_rvalid  out  1  spm_rd_data belongs to the MEM stage this cycle (registered).
- spm_addr  out  `WORD_ADDR_BUS`  address driven to the SPM.
- spm_as_  out  1  SPM strobe, active-low.
- spm_rw  out  1  SPM read/write.
- spm_wr_data  out  `WORD_DATA_BUS`  SPM write data.
- spm_rd_data  in  `WORD_DATA_BUS`  SPM read data, valid the cycle after a read is granted; fanned out to both ports and qualified by the *_rvalid outputs.

## Operation
- Request from a port: its as_ equals `ENABLE_`. A requester holds its request fields stable until it sees gnt. It may present the next request in the cycle right after gnt.
- Priority rule: MEM wins by default.
  - IF wins when MEM is idle.
  - IF also wins when the starvation counter equals STARVE_LIMIT.
- Exactly one gnt is asserted when any request is present; none otherwise.
- SPM port muxing:
  - spm_addr, spm_rw and spm_wr_data follow the granted port.
  - spm_as_ = `ENABLE_` only when a grant is issued.
  - When IF is granted: spm_rw = `READ` and spm_wr_data = mem_wr_data (don't care).
- Response tracking (owner register, values NONE/IF/MEM):
  - At each edge the owner register loads the granted port if the access is a read, otherwise NONE.
  - if_rvalid = (owner == IF); mem_rvalid = (owner == MEM).
- MEM writes complete at the grant edge and produce no rvalid.
- Starvation counter (4 bits):
  - Increments on each edge where MEM is granted and IF is requesting.
  - Clears on any IF grant, and on any edge where IF is not requesting.
  - Saturates at STARVE_LIMIT.
- Boundary cases:
  - Simultaneous requests with counter < STARVE_LIMIT → MEM granted, counter +1.
  - Simultaneous requests with counter == STARVE_LIMIT → IF granted, counter cleared.
  - Back-to-back reads from one port → one grant per cycle; rvalid appears one cycle later at full throughput.
  - MEM write in the cycle after an IF read → if_rvalid is still asserted for the earlier read. The write proceeds because the SPM port is free in that cycle.

## Timing
- Grant latency: zero cycles (combinational from as_ and the counter).
- Read data latency: one cycle after the grant edge.
- While reset is asserted, all outputs are forced inactive: if_gnt = mem_gnt = 0, if_rvalid = mem_rvalid = 0, spm_as_ = `DISABLE_`, spm_rw = `READ`, spm_addr = 0.
- Registers at reset: owner = NONE, counter = 0.
- Reset asserted mid-operation: a pending rvalid is discarded; no SPM access is issued until the first edge after reset is released.
- Stall condition exported to pipeline control: as_ == `ENABLE_` && !gnt for that port.

## Configuration
- `SPM_ARB_STARVE_EN`
  - Defined: starvation counter and STARVE_LIMIT override are compiled in, as described above.
  - Undefined: strict MEM priority; the counter is removed, STARVE_LIMIT is ignored, and IF is granted only when mem_as_ = `DISABLE_`.

## Structure
- Shared header spm.h holds:
  - `SPM_OWNER_BUS` (2 bits) with `SPM_OWNER_NONE`/`SPM_OWNER_IF`/`SPM_OWNER_MEM`;
  - `SPM_STARVE_CNT_BUS` (4 bits).
- Widths `WORD_ADDR_BUS`/`WORD_DATA_BUS`, `ENABLE_`/`DISABLE_` and `READ`/`WRITE` come from the existing headers.
- One sub-module: spm_arb_starve_ctr. It contains the counter and the "force IF" output, and is instantiated only under `SPM_ARB_STARVE_EN`.

## Test plan
- IF only: if_addr = 0x55, SPM returns 0x24 → if_gnt = 1 that cycle, spm_addr = 0x55, spm_rw = `READ`; next cycle if_rvalid = 1, mem_rvalid = 0, rd_data = 0x24.
- MEM write only: mem_addr = 0x10, mem_wr_data = 0x999, `WRITE` → mem_gnt = 1, spm_wr_data = 0x999, spm_rw = `WRITE`; no rvalid the next cycle.
- Simultaneous single requests: IF 0x20 and MEM read 0x30 → mem_gnt first (spm_addr = 0x30) while IF stalls; IF granted the next cycle; rvalid order MEM then IF.
- Starvation with STARVE_LIMIT = 4 (macro on): MEM and IF both request continuously → 4 MEM grants, then 1 IF grant, repeating. With the macro off → IF is never granted.
- Reset: assert reset (0) the cycle after an IF read grant → if_rvalid = 0 immediately, spm_as_ = `DISABLE_`; after release, the first grant comes with counter = 0.

Source files
------------

// File: rtl/spm_arbiter_pkg.sv
// Shared types and constants for the scratch-pad memory arbiter.
// Word widths, strobe/read-write encodings, response owner and counter width.
package spm_arbiter_pkg;

    // Word address and data widths of the SPM
    localparam int WORD_ADDR_W  = 30;
    localparam int WORD_DATA_W  = 32;

    // Active-low strobe encodings
    localparam logic ENABLE_     = 1'b0;
    localparam logic DISABLE_    = 1'b1;

    // Bus direction encodings
    localparam logic READ        = 1'b1;
    localparam logic WRITE       = 1'b0;

    // Starvation counter width
    localparam int STARVE_CNT_W = 4;

    // Port that owns the read currently in flight through the SPM
    typedef enum logic [1:0] {
        SPM_OWNER_NONE = 2'd0,
        SPM_OWNER_IF   = 2'd1,
        SPM_OWNER_MEM  = 2'd2
    } spm_owner_e;

endpackage : spm_arbiter_pkg

// File: rtl/spm_arb_starve_ctr.sv
// Starvation counter for the SPM arbiter.
// Counts consecutive MEM grants while the fetch port waits and raises
// o_force_if once the count reaches STARVE_LIMIT (legal range 1-15).
// Only instantiated when SPM_ARB_STARVE_EN is defined.
module spm_arb_starve_ctr
    import spm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_if_req,
    input  logic i_if_gnt,
    input  logic i_mem_gnt,
    output logic o_force_if
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count MEM wins over a waiting IF; clear when IF wins or stops asking
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt <= '0;
        end else if (i_if_gnt || !i_if_req) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of its inputs.
            r_cnt <= '0;
        end else if (i_mem_gnt && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force_if = (r_cnt == LIMIT);

endmodule : spm_arb_starve_ctr

// File: rtl/spm_arbiter.sv
// Two-requester arbiter for the single-port scratch-pad memory.
// MEM stage has priority over instruction fetch; grants are combinational,
// read responses are steered back one cycle later via an owner register.
// Optional feature macro: SPM_ARB_STARVE_EN enables the starvation counter
// that forces an IF grant after STARVE_LIMIT consecutive MEM wins.
module spm_arbiter
    import spm_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    // Instruction fetch port (read only)
    input  logic [WORD_ADDR_W-1:0] i_if_addr,
    input  logic                   i_if_as_,
    output logic                   o_if_gnt,
    output logic                   o_if_rvalid,
    // MEM-stage port
    input  logic [WORD_ADDR_W-1:0] i_mem_addr,
    input  logic                   i_mem_as_,
    input  logic                   i_mem_rw,
    input  logic [WORD_DATA_W-1:0] i_mem_wr_data,
    output logic                   o_mem_gnt,
    output logic                   o_mem_rvalid,
    // SPM side
    output logic [WORD_ADDR_W-1:0] o_spm_addr,
    output logic                   o_spm_as_,
    output logic                   o_spm_rw,
    output logic [WORD_DATA_W-1:0] o_spm_wr_data,
    input  logic [WORD_DATA_W-1:0] i_spm_rd_data
);

    logic       w_if_req;
    logic       w_mem_req;
    logic       w_if_wins;
    spm_owner_e w_owner_nxt;
    spm_owner_e r_owner;

    // Requests are masked while reset is asserted so no grant or SPM access
    // can escape before the first edge after release.
    assign w_if_req  = i_reset && (i_if_as_  == ENABLE_);
    assign w_mem_req = i_reset && (i_mem_as_ == ENABLE_);

`ifdef SPM_ARB_STARVE_EN
    logic w_force_if;

    spm_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_if_req   (w_if_req),
        .i_if_gnt   (o_if_gnt),
        .i_mem_gnt  (o_mem_gnt),
        .o_force_if (w_force_if)
    );

    assign w_if_wins = w_if_req && (!w_mem_req || w_force_if);
`else
    // Strict MEM priority: the limit has no effect in this build
    logic [31:0] w_unused_starve_limit;
    assign w_unused_starve_limit = 32'(STARVE_LIMIT);

    assign w_if_wins = w_if_req && !w_mem_req;
`endif

    assign o_if_gnt  = w_if_wins;
    assign o_mem_gnt = w_mem_req && !w_if_wins;

    // Steer the granted port onto the SPM; idle values when nothing is granted
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        o_spm_addr    = '0;
        o_spm_as_     = DISABLE_;
        o_spm_rw      = READ;
        o_spm_wr_data = i_mem_wr_data;
        w_owner_nxt   = SPM_OWNER_NONE;
        if (o_if_gnt) begin
            o_spm_addr  = i_if_addr;
            o_spm_as_   = ENABLE_;
            w_owner_nxt = SPM_OWNER_IF;
        end else if (o_mem_gnt) begin
            o_spm_addr  = i_mem_addr;
            o_spm_as_   = ENABLE_;
            o_spm_rw    = i_mem_rw;
            w_owner_nxt = (i_mem_rw == READ) ? SPM_OWNER_MEM : SPM_OWNER_NONE;
        end
    end

    // Remember which port owns the read returning in the next cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        // NOTE: asynchronous reset clears the owner at once, so a pending
        // rvalid disappears the moment reset is asserted.
        if (!i_reset) begin
            r_owner <= SPM_OWNER_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign o_if_rvalid  = (r_owner == SPM_OWNER_IF);
    assign o_mem_rvalid = (r_owner == SPM_OWNER_MEM);

    // Read data fans out directly to both ports; the rvalids qualify it
    logic [WORD_DATA_W-1:0] w_unused_rd_data;
    assign w_unused_rd_data = i_spm_rd_data;

endmodule : spm_arbiter
